// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C command arbiter.
package i2c_arb_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } arb_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/i2c_arb_rr.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module i2c_arb_rr (
  input  logic [1:0] i_valid,
  input  logic       i_lg,
  output logic       o_grant,
  output logic       o_any
);

  assign o_any   = |i_valid;
  assign o_grant = (&i_valid) ? ~i_lg : i_valid[1];

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Two-requester arbiter/sequencer in front of the single I2C master engine.
// Optional build macro: I2C_ARB_TIMEOUT_EN adds the WAIT_DONE timeout counter.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | ready offered to the round-robin winner, waiting for a command
// ST_ISSUE     | command latched, waiting for m_busy=0 to pulse m_start
// ST_WAIT_DONE | engine running, waiting for m_done (or timeout)
// ST_RESP      | response held on the owner's channel until taken
module i2c_cmd_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_W           = 16
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [I2C_ADDR_W-1:0] req0_addr,
  input  logic                  req0_rw,
  input  logic [I2C_DATA_W-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [I2C_ADDR_W-1:0] req1_addr,
  input  logic                  req1_rw,
  input  logic [I2C_DATA_W-1:0] req1_wdata,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [I2C_DATA_W-1:0] rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  m_start,
  output logic [I2C_ADDR_W-1:0] m_addr,
  output logic                  m_rw,
  output logic [I2C_DATA_W-1:0] m_wdata,
  input  logic                  m_busy,
  input  logic                  m_done,
  input  logic                  m_nack,
  input  logic [I2C_DATA_W-1:0] m_rdata
);

  if ((TIMEOUT_CYCLES < 2) || ((TIMEOUT_CYCLES >> TO_W) != 0)) begin : g_bad_cfg
    $error("i2c_cmd_arbiter: TIMEOUT_CYCLES must be >= 2 and fit in TO_W bits");
  end

  arb_state_e            r_state;
  logic                  r_lg;
  logic                  r_owner;
  logic [I2C_ADDR_W-1:0] r_addr;
  logic                  r_rw;
  logic [I2C_DATA_W-1:0] r_wdata;
  logic [I2C_DATA_W-1:0] r_rdata;
  logic [1:0]            r_err;

  logic w_grant;
  logic w_any;
  logic w_rsp_take;
  logic w_to_hit;

  i2c_arb_rr u_rr (
    .i_valid ({req1_valid, req0_valid}),
    .i_lg    (r_lg),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  assign req0_ready = (r_state == ST_IDLE) && w_any && !w_grant;
  assign req1_ready = (r_state == ST_IDLE) && w_any &&  w_grant;

  // m_start is combinational so it fires in the same cycle the engine frees up.
  assign m_start    = (r_state == ST_ISSUE) && !m_busy;
  assign rsp0_valid = (r_state == ST_RESP) && !r_owner;
  assign rsp1_valid = (r_state == ST_RESP) &&  r_owner;
  assign w_rsp_take = r_owner ? rsp1_ready : rsp0_ready;

  assign m_addr    = r_addr;
  assign m_rw      = r_rw;
  assign m_wdata   = r_wdata;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

`ifdef I2C_ARB_TIMEOUT_EN
  // Hit fires in the cycle where the post-increment count reaches TIMEOUT_CYCLES-1,
  // so the timeout response appears TIMEOUT_CYCLES cycles after m_start.
  localparam logic [TO_W-1:0] TO_HIT = TO_W'(TIMEOUT_CYCLES - 2);
  logic [TO_W-1:0] r_to_cnt;

  // Timeout counter: cleared on m_start, counts every WAIT_DONE cycle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_to_cnt <= '0;
    end else if (m_start) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_WAIT_DONE) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_to_hit = (r_state == ST_WAIT_DONE) && (r_to_cnt == TO_HIT);
`else
  assign w_to_hit = 1'b0;
`endif

  // Main sequencer: accept, issue, wait for completion, hand back the response.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= ST_IDLE;
      r_lg    <= 1'b1;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= ERR_OK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner <= w_grant;
            r_lg    <= w_grant;
            r_addr  <= w_grant ? req1_addr  : req0_addr;
            r_rw    <= w_grant ? req1_rw    : req0_rw;
            r_wdata <= w_grant ? req1_wdata : req0_wdata;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!m_busy) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (m_done) begin
            r_rdata <= m_rdata;
            r_err   <= m_nack ? ERR_NACK : ERR_OK;
            r_state <= ST_RESP;
          end else if (w_to_hit) begin
            r_rdata <= '0;
            r_err   <= ERR_TIMEOUT;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_rsp_take) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Self-checking bench for i2c_cmd_arbiter. Build with +define+I2C_ARB_TIMEOUT_EN
// to exercise the timeout path; the default build checks that no timeout occurs.
module tb_i2c_cmd_arbiter;

  localparam int TO_CYC = 100;

  logic       clk = 1'b0;
  logic       res_n;
  logic       req0_valid, req0_ready, req0_rw;
  logic [6:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req1_valid, req1_ready, req1_rw;
  logic [6:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       m_start, m_rw, m_busy, m_done, m_nack;
  logic [6:0] m_addr;
  logic [7:0] m_wdata, m_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit m_lg;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_cmd_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(16)) dut (
    .clk(clk), .res_n(res_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_rw(req0_rw), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_rw(req1_rw), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
    .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    req0_valid = 0; req0_addr = 0; req0_rw = 0; req0_wdata = 0;
    req1_valid = 0; req1_addr = 0; req1_rw = 0; req1_wdata = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    m_busy = 0; m_done = 0; m_nack = 0; m_rdata = 0;
  endtask

  // Ends aligned just after a falling edge.
  task automatic apply_reset();
    res_n = 0;
    clear_inputs();
    repeat (3) @(negedge clk);
    res_n = 1;
    m_lg  = 1;
  endtask

  // Runs one transaction with an engine model. Called and returns just after a falling edge.
  task automatic do_txn(input int busy_n, input int done_dly, input bit send_done,
                        input bit nack, input logic [7:0] rd, input bit hold,
                        output int owner, output int t_acc, output int t_start,
                        output logic [6:0] s_addr, output logic s_rw, output logic [7:0] s_wd,
                        output int t_rsp, output int rsp_ch, output logic [7:0] r_rd,
                        output logic [1:0] r_err, output int n_start, output int t_hs,
                        output bit ok);
    int phase  = 0;
    int budget = 0;
    owner = -1; t_acc = -1; t_start = -1; t_rsp = -1; rsp_ch = -1; t_hs = -1;
    n_start = 0; ok = 0; s_addr = 0; s_rw = 0; s_wd = 0; r_rd = 0; r_err = 0;
    while (phase < 4 && budget < 400) begin
      m_done     = 0;
      m_nack     = 1'($urandom_range(0, 1));
      m_rdata    = 8'($urandom);
      rsp0_ready = 0;
      rsp1_ready = 0;
      m_busy     = (phase == 1) && (cyc - t_acc <= busy_n);
      if (phase == 1 && !hold && cyc == t_acc + 1) begin
        if (owner == 0) req0_valid = 0; else req1_valid = 0;
      end
      if (phase == 2 && send_done && (cyc - t_start == done_dly)) begin
        m_done = 1; m_nack = nack; m_rdata = rd;
      end
      if (phase == 3) begin
        rsp0_ready = (rsp_ch == 0);
        rsp1_ready = (rsp_ch == 1);
        t_hs = cyc;
      end
      #1;
      if (m_start) n_start++;
      case (phase)
        0: begin
          if (req0_valid && req0_ready) owner = 0;
          else if (req1_valid && req1_ready) owner = 1;
          if (owner >= 0) begin t_acc = cyc; phase = 1; end
        end
        1: if (m_start) begin
          t_start = cyc; s_addr = m_addr; s_rw = m_rw; s_wd = m_wdata; phase = 2;
        end
        2: if (rsp0_valid || rsp1_valid) begin
          t_rsp = cyc;
          rsp_ch = (rsp0_valid && rsp1_valid) ? 2 : (rsp1_valid ? 1 : 0);
          r_rd = rsp_rdata; r_err = rsp_err; phase = 3;
        end
        default: begin
          if (!((rsp_ch == 0 && rsp0_valid) || (rsp_ch == 1 && rsp1_valid))) rsp_ch = 3;
          phase = 4; ok = 1;
        end
      endcase
      @(negedge clk);
      budget++;
    end
    rsp0_ready = 0; rsp1_ready = 0; m_done = 0; m_busy = 0;
  endtask

  task automatic test_reset();
    res_n = 0;
    clear_inputs();
    @(negedge clk); #1;
    if ({req1_ready, req0_ready} !== 2'b00) begin n_bad++; $display("FAIL rst_ready: got %b want 00", {req1_ready, req0_ready}); end
    n_cmp++;
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 00", {rsp1_valid, rsp0_valid}); end
    n_cmp++;
    if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got %h want 00", rsp_rdata); end
    n_cmp++;
    if (rsp_err !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %b want 00", rsp_err); end
    n_cmp++;
    if ({m_start, m_rw, m_addr, m_wdata} !== 17'h0) begin n_bad++; $display("FAIL rst_master: got %h want 0", {m_start, m_rw, m_addr, m_wdata}); end
    n_cmp++;
    @(negedge clk);
    res_n = 1;
    m_lg  = 1;
  endtask

  task automatic test_single_write();
    int ow, ta, ts, tr, ch, ns, th; logic [6:0] sa; logic sr; logic [7:0] sw, rr; logic [1:0] re; bit ok;
    req0_addr = 7'h50; req0_rw = 0; req0_wdata = 8'hAA; req0_valid = 1; req1_valid = 0;
    do_txn(0, 20, 1, 0, 8'($urandom), 0, ow, ta, ts, sa, sr, sw, tr, ch, rr, re, ns, th, ok);
    if (ok !== 1'b1) begin n_bad++; $display("FAIL wr_complete: got %0d want 1", ok); end
    n_cmp++;
    if (ow != 0) begin n_bad++; $display("FAIL wr_owner: got %0d want 0", ow); end
    n_cmp++;
    if (ts != ta + 1) begin n_bad++; $display("FAIL wr_start_lat: got %0d want %0d", ts, ta + 1); end
    n_cmp++;
    if (sa !== 7'h50 || sw !== 8'hAA || sr !== 1'b0) begin n_bad++; $display("FAIL wr_cmd: got %h/%b/%h want 50/0/aa", sa, sr, sw); end
    n_cmp++;
    if (ch != 0 || re !== 2'b00) begin n_bad++; $display("FAIL wr_rsp: got ch %0d err %b want ch 0 err 00", ch, re); end
    n_cmp++;
    if (tr != ts + 21) begin n_bad++; $display("FAIL wr_rsp_lat: got %0d want %0d", tr, ts + 21); end
    n_cmp++;
    if (ns != 1) begin n_bad++; $display("FAIL wr_start_count: got %0d want 1", ns); end
    n_cmp++;
    m_lg = 0;
  endtask

  task automatic test_read();
    int ow, ta, ts, tr, ch, ns, th; logic [6:0] sa; logic sr; logic [7:0] sw, rr; logic [1:0] re; bit ok;
    int dly = $urandom_range(1, 30);
    req1_addr = 7'h3C; req1_rw = 1; req1_wdata = 8'($urandom); req1_valid = 1;
    do_txn(0, dly, 1, 0, 8'h5A, 0, ow, ta, ts, sa, sr, sw, tr, ch, rr, re, ns, th, ok);
    if (ow != 1 || sa !== 7'h3C || sr !== 1'b1) begin n_bad++; $display("FAIL rd_cmd: got owner %0d %h/%b want 1 3c/1", ow, sa, sr); end
    n_cmp++;
    if (ch != 1 || rr !== 8'h5A || re !== 2'b00) begin n_bad++; $display("FAIL rd_rsp: got ch %0d data %h err %b want 1 5a 00", ch, rr, re); end
    n_cmp++;
    if (tr != ts + dly + 1) begin n_bad++; $display("FAIL rd_rsp_lat: got %0d want %0d", tr, ts + dly + 1); end
    n_cmp++;
    m_lg = 1;
  endtask

  task automatic test_nack();
    int ow, ta, ts, tr, ch, ns, th, t0, extra; logic [6:0] sa; logic sr; logic [7:0] sw, rr; logic [1:0] re; bit ok;
    bit late_rsp = 0;
    req0_addr = 7'($urandom); req0_rw = 0; req0_wdata = 8'($urandom); req0_valid = 1;
    do_txn(0, 5, 1, 1, 8'($urandom), 0, ow, ta, ts, sa, sr, sw, tr, ch, rr, re, ns, th, ok);
    m_lg = 0;
    if (ch != 0 || re !== 2'b01) begin n_bad++; $display("FAIL nack_rsp: got ch %0d err %b want 0 01", ch, re); end
    n_cmp++;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      m_done = (i == 3); m_nack = 1'(i == 3); m_rdata = 8'hC3;
      #1;
      if (m_start) extra++;
      if (rsp0_valid || rsp1_valid) late_rsp = 1;
      @(negedge clk);
    end
    m_done = 0;
    if (extra != 0) begin n_bad++; $display("FAIL nack_retry: got %0d starts want 0", extra); end
    n_cmp++;
    if (late_rsp !== 1'b0) begin n_bad++; $display("FAIL idle_done_ignored: got rsp %0d want 0", late_rsp); end
    n_cmp++;
    t0 = cyc;
    req0_valid = 1;
    do_txn(0, 3, 1, 0, 8'($urandom), 0, ow, ta, ts, sa, sr, sw, tr, ch, rr, re, ns, th, ok);
    if (ta != t0) begin n_bad++; $display("FAIL nack_back_idle: got accept %0d want %0d", ta, t0); end
    n_cmp++;
    m_lg = 0;
  endtask

  task automatic test_busy();
    int ow, ta, ts, tr, ch, ns, th; logic [6:0] sa; logic sr; logic [7:0] sw, rr; logic [1:0] re; bit ok;
    req1_addr = 7'($urandom); req1_rw = 0; req1_wdata = 8'($urandom); req1_valid = 1;
    do_txn(50, 4, 1, 0, 8'($urandom), 0, ow, ta, ts, sa, sr, sw, tr, ch, rr, re, ns, th, ok);
    if (ts != ta + 51) begin n_bad++; $display("FAIL busy_start: got %0d want %0d", ts, ta + 51); end
    n_cmp++;
    if (ns != 1) begin n_bad++; $display("FAIL busy_start_count: got %0d want 1", ns); end
    n_cmp++;
    m_lg = 1;
  endtask

  task automatic test_back_to_back();
    int ow, ta, ts, tr, ch, ns, th, prev_hs, exp_ow; logic [6:0] sa; logic sr; logic [7:0] sw, rr; logic [1:0] re; bit ok;
    logic [6:0] a [2];
    apply_reset();
    a[0] = 7'($urandom); a[1] = 7'($urandom);
    req0_addr = a[0]; req1_addr = a[1]; req0_rw = 0; req1_rw = 1;
    req0_wdata = 8'($urandom); req1_wdata = 8'($urandom);
    req0_valid = 1; req1_valid = 1;
    prev_hs = -1;
    for (int i = 0; i < 4; i++) begin
      do_txn(0, $urandom_range(1, 8), 1, 0, 8'($urandom), 1, ow, ta, ts, sa, sr, sw, tr, ch, rr, re, ns, th, ok);
      exp_ow = m_lg ? 0 : 1;
      if (ow != exp_ow || ch != exp_ow) begin n_bad++; $display("FAIL tie_grant%0d: got owner %0d ch %0d want %0d", i, ow, ch, exp_ow); end
      n_cmp++;
      if (sa !== a[exp_ow]) begin n_bad++; $display("FAIL tie_addr%0d: got %h want %h", i, sa, a[exp_ow]); end
      n_cmp++;
      if (i > 0) begin
        if (ta != prev_hs + 1) begin n_bad++; $display("FAIL b2b_accept%0d: got %0d want %0d", i, ta, prev_hs + 1); end
        n_cmp++;
      end
      prev_hs = th;
      m_lg = exp_ow[0];
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_timeout();
    int ow, ta, ts, tr, ch, ns, th; logic [6:0] sa; logic sr; logic [7:0] sw, rr; logic [1:0] re; bit ok;
    bit late_rsp = 0;
    req0_addr = 7'($urandom); req0_rw = 1; req0_valid = 1;
`ifdef I2C_ARB_TIMEOUT_EN
    do_txn(0, 1, 0, 0, 8'h00, 0, ow, ta, ts, sa, sr, sw, tr, ch, rr, re, ns, th, ok);
    if (ok !== 1'b1 || tr != ts + TO_CYC) begin n_bad++; $display("FAIL to_lat: got %0d want %0d", tr - ts, TO_CYC); end
    n_cmp++;
    if (re !== 2'b10 || rr !== 8'h00 || ch != 0) begin n_bad++; $display("FAIL to_rsp: got err %b data %h ch %0d want 10 00 0", re, rr, ch); end
    n_cmp++;
    m_done = 1; m_nack = 0; m_rdata = 8'hE7;
    #1;
    @(negedge clk);
    m_done = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rsp0_valid || rsp1_valid || rsp_err !== 2'b10 || rsp_rdata !== 8'h00) late_rsp = 1;
      @(negedge clk);
    end
    if (late_rsp !== 1'b0) begin n_bad++; $display("FAIL to_late_done: got disturbed %0d want 0", late_rsp); end
    n_cmp++;
`else
    do_txn(0, 250, 1, 0, 8'h81, 0, ow, ta, ts, sa, sr, sw, tr, ch, rr, re, ns, th, ok);
    if (ok !== 1'b1 || tr != ts + 251) begin n_bad++; $display("FAIL no_to_lat: got %0d want 251", tr - ts); end
    n_cmp++;
    if (re !== 2'b00 || rr !== 8'h81) begin n_bad++; $display("FAIL no_to_rsp: got err %b data %h want 00 81", re, rr); end
    n_cmp++;
`endif
    m_lg = 0;
  endtask

  task automatic test_reset_mid();
    int ow, ta, ts, tr, ch, ns, th; logic [6:0] sa; logic sr; logic [7:0] sw, rr; logic [1:0] re; bit ok;
    bit got = 0, acc = 0;
    req0_addr = 7'h40 | 7'($urandom); req0_rw = 1; req0_wdata = 8'h80 | 8'($urandom); req0_valid = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (req0_ready) acc = 1;
      if (m_start) got = 1;
      @(negedge clk);
      if (acc) req0_valid = 0;
    end
    if (got !== 1'b1) begin n_bad++; $display("FAIL rmid_start: got %0d want 1", got); end
    n_cmp++;
    repeat (5) @(negedge clk);
    #2 res_n = 0;
    #1;
    if ({m_addr, m_rw, m_wdata, m_start} !== 17'h0) begin n_bad++; $display("FAIL rmid_master: got %h want 0", {m_addr, m_rw, m_wdata, m_start}); end
    n_cmp++;
    if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready, rsp_err} !== 6'h0 || rsp_rdata !== 8'h0) begin
      n_bad++; $display("FAIL rmid_rsp: got %b %h want 0", {rsp1_valid, rsp0_valid, req1_ready, req0_ready, rsp_err}, rsp_rdata);
    end
    n_cmp++;
    @(negedge clk);
    res_n = 1;
    m_lg  = 1;
    req0_valid = 1; req1_valid = 1;
    do_txn(5, 3, 1, 0, 8'($urandom), 0, ow, ta, ts, sa, sr, sw, tr, ch, rr, re, ns, th, ok);
    if (ow != 0 || ts != ta + 6) begin n_bad++; $display("FAIL rmid_restart: got owner %0d start %0d want 0 %0d", ow, ts, ta + 6); end
    n_cmp++;
    m_lg = 0;
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_random();
    int ow, ta, ts, tr, ch, ns, th, t0, v, bz, dl, exp_ow; logic [6:0] sa; logic sr; logic [7:0] sw, rr; logic [1:0] re; bit ok;
    logic [6:0] a [2]; logic w [2]; logic [7:0] d [2]; logic [7:0] rd; bit nk;
    for (int n = 0; n < 40; n++) begin
      v = $urandom_range(1, 3);
      for (int k = 0; k < 2; k++) begin a[k] = 7'($urandom); w[k] = 1'($urandom_range(0, 1)); d[k] = 8'($urandom); end
      req0_addr = a[0]; req0_rw = w[0]; req0_wdata = d[0]; req0_valid = v[0];
      req1_addr = a[1]; req1_rw = w[1]; req1_wdata = d[1]; req1_valid = v[1];
      bz = $urandom_range(0, 5); dl = $urandom_range(1, 15); nk = 1'($urandom_range(0, 1)); rd = 8'($urandom);
      exp_ow = (v == 3) ? (m_lg ? 0 : 1) : (v == 2 ? 1 : 0);
      t0 = cyc;
      do_txn(bz, dl, 1, nk, rd, 0, ow, ta, ts, sa, sr, sw, tr, ch, rr, re, ns, th, ok);
      if (ow != exp_ow || ta != t0) begin n_bad++; $display("FAIL rnd%0d_grant: got %0d@%0d want %0d@%0d", n, ow, ta, exp_ow, t0); end
      n_cmp++;
      if (sa !== a[exp_ow] || sr !== w[exp_ow] || sw !== d[exp_ow]) begin
        n_bad++; $display("FAIL rnd%0d_cmd: got %h/%b/%h want %h/%b/%h", n, sa, sr, sw, a[exp_ow], w[exp_ow], d[exp_ow]);
      end
      n_cmp++;
      if (ts != ta + 1 + bz || tr != ts + dl + 1) begin n_bad++; $display("FAIL rnd%0d_timing: got %0d/%0d want %0d/%0d", n, ts, tr, ta + 1 + bz, ta + 2 + bz + dl); end
      n_cmp++;
      if (ch != exp_ow || rr !== rd || re !== {1'b0, nk}) begin
        n_bad++; $display("FAIL rnd%0d_rsp: got ch %0d %h %b want %0d %h %b", n, ch, rr, re, exp_ow, rd, {1'b0, nk});
      end
      n_cmp++;
      m_lg = exp_ow[0];
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_read();
    test_nack();
    test_busy();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_arbiter.md
# i2c_cmd_arbiter

Two-requester arbiter and sequencer for the single I2C master engine behind the AXI-to-I2C bridge. Each requester submits a one-byte I2C command (7-bit address, read/write, write data). The block grants the engine round-robin, pulses its start, waits for completion, and returns read data plus a status code to the owning requester. It sits between the bridge's register front end (or on-chip agents) and the I2C master core, so no requester drives the engine's start/address/data directly.

## Interface
- TIMEOUT_CYCLES, 65535: clk cycles allowed between m_start and m_done before a timeout error.
- TO_W, 16: width of the timeout counter; must hold TIMEOUT_CYCLES.
- clk  in  1  system clock; all logic on rising edge.
- res_n  in  1  reset, asynchronous, active-low.
- req0_valid / req1_valid  in  1  command pending.
- req0_ready / req1_ready  out  1  command accepted this cycle when valid&ready.
- req0_addr / req1_addr  in  7  I2C slave address.
- req0_rw / req1_rw  in  1  1=read, 0=write.
- req0_wdata / req1_wdata  in  8  write byte (ignored for reads).
- rsp0_valid / rsp1_valid  out  1  response available, held until taken.
- rsp0_ready / rsp1_ready  in  1  requester takes response.
- rsp_rdata  out  8  read byte, shared by both response channels (valid only with rspN_valid).
- rsp_err  out  2  00 OK, 01 NACK, 10 TIMEOUT, 11 reserved.
- m_start  out  1  one-cycle start pulse to the I2C master.
- m_addr / m_rw / m_wdata  out  7/1/8  latched command, stable from m_start until the response.
- m_busy  in  1  engine busy.
- m_done  in  1  one-cycle completion pulse.
- m_nack  in  1  slave NACK, valid with m_done.
- m_rdata  in  8  read byte, valid with m_done.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE: grant computed combinationally from the valids and a last-grant pointer `lg`.
  - Only one valid: grant it.
  - Both valid: grant !lg.
  - reqN_ready = (state==IDLE) && grant==N.
  - On handshake: latch addr/rw/wdata and owner, set lg=owner, go to ISSUE.
- ISSUE: while m_busy=1, wait. When m_busy=0, pulse m_start for one cycle, clear the timeout counter, go to WAIT_DONE.
- WAIT_DONE: on m_done:
  - capture m_rdata into rsp_rdata;
  - set rsp_err = m_nack ? 01 : 00;
  - go to RESP.
- RESP: rsp<owner>_valid=1; the other rspN_valid stays 0. On rsp<owner>_ready, go to IDLE.
- m_done outside WAIT_DONE is ignored (covers a late completion after a timeout).
- NACK is reported, never retried.

## Timing
- Reset values: req*_ready=0, rsp*_valid=0, rsp_rdata=0, rsp_err=00, m_start=0, m_addr=0, m_rw=0, m_wdata=0, lg=1 (requester 0 wins the first tie), state=IDLE.
- Reset mid-transaction aborts immediately. The engine is not notified; the next ISSUE waits for m_busy=0.
- Accept at cycle N gives m_start at N+1 if m_busy=0 at N+1; otherwise m_start comes on the first cycle with m_busy=0.
- m_done at cycle D gives rspN_valid at D+1.
- A response handshake at cycle R allows the next accept at R+1 at the earliest. Throughput is one command per transaction; no queuing.
- reqN_ready is 0 in every non-IDLE state, so valids may stay high and are simply held off.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - In WAIT_DONE the counter increments each cycle.
  - If it reaches TIMEOUT_CYCLES-1 with no m_done, the block goes to RESP with rsp_err=10 and rsp_rdata=0.
  - If m_done and the timeout hit occur in the same cycle, m_done wins.
- Not defined: no counter is built; WAIT_DONE waits indefinitely; code 10 is never produced.

## Structure
- Shared package i2c_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT_DONE, RESP);
  - rsp_err codes ERR_OK, ERR_NACK, ERR_TIMEOUT;
  - I2C_ADDR_W=7, I2C_DATA_W=8.
- One sub-module, i2c_arb_rr: combinational 2-way round-robin pick (valids, lg -> grant, any). It is reused when the bridge grows more requesters.

## Test plan
- Single write: req0 addr 0x50, rw=0, wdata 0xAA; model pulses m_done 20 cycles after m_start with m_nack=0. Required:
  - m_start exactly one cycle after accept;
  - m_addr=0x50, m_wdata=0xAA;
  - rsp0_valid with rsp_err=00; rsp1_valid stays 0.
- Read: req1 addr 0x3C, rw=1; model returns m_rdata=0x5A. Required: rsp1_valid, rsp_rdata=0x5A, rsp_err=00.
- Tie: both valid from reset, held. Required: grants in order 0, 1, 0, 1 across four transactions; each requester's response arrives on its own channel.
- NACK: model returns m_nack=1. Required: rsp_err=01, no retry, block back in IDLE after the rsp handshake.
- Busy hold-off: m_busy=1 for 50 cycles after accept. Required: no m_start until the cycle m_busy falls.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, model never sends m_done. Required:
  - rsp_err=10 exactly 100 cycles after m_start;
  - a late m_done in IDLE is ignored.
  - Also: assert res_n low in WAIT_DONE; all outputs return to their reset values asynchronously.
